// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 ramp sequencer: state codes, the period floor
// and the start-period default, which is chosen by whether the code is synthesised or simulated.
package motoro3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_BRAKE = 3'd4
    } state_t;

    localparam logic [24:0] MIN_PERIOD         = 25'd1_667;
    localparam logic [24:0] START_PERIOD_SYNTH = 25'd1_666_667;
    localparam logic [24:0] START_PERIOD_SIM   = 25'd20_000;

`ifdef SYNTHESIS
    localparam logic [24:0] START_PERIOD_DFLT  = START_PERIOD_SYNTH;
`else
    localparam logic [24:0] START_PERIOD_DFLT  = START_PERIOD_SIM;
`endif

endpackage

// File: rtl/motoro3_ramp_step.sv
// Combinational saturating step of 'now' toward 'tgt' by at most 'step'.
module motoro3_ramp_step #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] now,
    input  logic [W-1:0] tgt,
    input  logic [W-1:0] step,
    output logic [W-1:0] next
);

    // Distance is tested before the add/subtract, so neither direction can wrap.
    always_comb begin
        next = now;
        if (now > tgt) begin
            next = (now - tgt < step) ? tgt : now - step;
        end else if (now < tgt) begin
            next = (tgt - now < step) ? tgt : now + step;
        end
    end

endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Soft-start sequencer: align the rotor, ramp period and power toward their targets
// one step per commutation, hold at speed, and brake on stop.
module motoro3_ramp_ctrl
    import motoro3_pkg::*;
#(
    parameter logic [23:0] ALIGN_CLKS   = 24'd2_000_000,
    parameter logic [7:0]  ALIGN_POWER  = 8'h08,
    parameter logic [24:0] START_PERIOD = START_PERIOD_DFLT,
    parameter logic [24:0] RAMP_STEP    = 25'd1_000,
    parameter logic [23:0] BRAKE_CLKS   = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [24:0] m3r_stepCNT_speedSET,
    input  logic [7:0]  m3r_power_percent,
    input  logic        m3c_start,
    input  logic        m3c_stepTick,
    output logic [24:0] m3c_stepCNT_now,
    output logic [7:0]  m3c_power_now,
    output logic        m3c_runEn,
    output logic        m3c_alignEn,
    output logic        m3c_atSpeed,
    output logic [2:0]  m3c_state
);

    state_t      state;
    logic [23:0] cnt;
    logic [24:0] per_tgt;
    logic [24:0] per_next;
    logic [7:0]  pow_tgt;
    logic [7:0]  pow_next;
    logic        on_target;

    always_comb begin
        per_tgt   = (m3r_stepCNT_speedSET < MIN_PERIOD) ? MIN_PERIOD : m3r_stepCNT_speedSET;
        pow_tgt   = (m3r_power_percent == 8'd0) ? 8'd1 : m3r_power_percent;
        on_target = (m3c_stepCNT_now == per_tgt) && (m3c_power_now == pow_tgt);
    end

    motoro3_ramp_step #(.W(25)) u_per_step (
        .now  (m3c_stepCNT_now),
        .tgt  (per_tgt),
        .step (RAMP_STEP),
        .next (per_next)
    );

    motoro3_ramp_step #(.W(8)) u_pow_step (
        .now  (m3c_power_now),
        .tgt  (pow_tgt),
        .step (8'd1),
        .next (pow_next)
    );

    assign m3c_state = state;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            m3c_stepCNT_now <= START_PERIOD;
            m3c_power_now   <= '0;
            m3c_runEn       <= 1'b0;
            m3c_alignEn     <= 1'b0;
            m3c_atSpeed     <= 1'b0;
        end else if (!m3c_start && (state inside {ST_ALIGN, ST_RAMP, ST_RUN})) begin
            // Stop wins over any same-cycle tick; the period is left where it was.
            state         <= ST_BRAKE;
            cnt           <= BRAKE_CLKS - 24'd1;
            m3c_power_now <= '0;
            m3c_runEn     <= 1'b0;
            m3c_alignEn   <= 1'b0;
            m3c_atSpeed   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m3c_start) begin
                        state         <= ST_ALIGN;
                        cnt           <= ALIGN_CLKS - 24'd1;
                        m3c_power_now <= ALIGN_POWER;
                        m3c_alignEn   <= 1'b1;
                    end
                end
                ST_ALIGN: begin
                    if (cnt == '0) begin
                        state           <= ST_RAMP;
                        m3c_alignEn     <= 1'b0;
                        m3c_runEn       <= 1'b1;
                        m3c_stepCNT_now <= START_PERIOD;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
                ST_RAMP: begin
                    if (on_target) begin
                        state       <= ST_RUN;
                        m3c_atSpeed <= 1'b1;
                    end else if (m3c_stepTick) begin
                        m3c_stepCNT_now <= per_next;
                        m3c_power_now   <= pow_next;
                    end
                end
                ST_RUN: begin
                    if (!on_target) begin
                        state       <= ST_RAMP;
                        m3c_atSpeed <= 1'b0;
                    end
                end
                ST_BRAKE: begin
                    if (cnt == '0) begin
                        state           <= ST_IDLE;
                        m3c_stepCNT_now <= START_PERIOD;
                    end else begin
                        cnt <= cnt - 24'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Bench for motoro3_ramp_ctrl: directed vector table for the bring-up/ramp/stop sequence,
// then random stimulus checked every cycle against a spec-level reference model.
module tb_motoro3_ramp_ctrl;

    localparam int ALIGN_N   = 100;
    localparam int BRAKE_N   = 50;
    localparam int START_P   = 20000;
    localparam int STEP_P    = 1000;
    localparam int MIN_P     = 1667;
    localparam int ALIGN_PWR = 8;

    logic        clk = 1'b0;
    logic        nRst;
    logic [24:0] spd;
    logic [7:0]  pw;
    logic        start;
    logic        tick;
    logic [24:0] per_now;
    logic [7:0]  pow_now;
    logic        run_en;
    logic        align_en;
    logic        at_speed;
    logic [2:0]  st;

    int vecs = 0;
    int errs = 0;

    motoro3_ramp_ctrl #(
        .ALIGN_CLKS   (24'd100),
        .ALIGN_POWER  (8'h08),
        .START_PERIOD (25'd20_000),
        .RAMP_STEP    (25'd1_000),
        .BRAKE_CLKS   (24'd50)
    ) dut (
        .clk                  (clk),
        .nRst                 (nRst),
        .m3r_stepCNT_speedSET (spd),
        .m3r_power_percent    (pw),
        .m3c_start            (start),
        .m3c_stepTick         (tick),
        .m3c_stepCNT_now      (per_now),
        .m3c_power_now        (pow_now),
        .m3c_runEn            (run_en),
        .m3c_alignEn          (align_en),
        .m3c_atSpeed          (at_speed),
        .m3c_state            (st)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0..4 = idle, align, ramp, run, brake
    int m_phase, m_cnt, m_per, m_pow;
    bit m_run, m_align, m_at;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_per = START_P; m_pow = 0;
        m_run = 0; m_align = 0; m_at = 0;
    endtask

    task automatic model_clk(input bit s, input bit t, input int sp, input int p);
        int tp, tw;
        tp = imax(sp, MIN_P);
        tw = imax(p, 1);
        if (!s && m_phase >= 1 && m_phase <= 3) begin
            m_phase = 4; m_cnt = BRAKE_N - 1; m_pow = 0;
            m_run = 0; m_align = 0; m_at = 0;
        end else if (m_phase == 0) begin
            if (s) begin m_phase = 1; m_cnt = ALIGN_N - 1; m_pow = ALIGN_PWR; m_align = 1; end
        end else if (m_phase == 1) begin
            if (m_cnt == 0) begin m_phase = 2; m_align = 0; m_run = 1; m_per = START_P; end
            else m_cnt--;
        end else if (m_phase == 2) begin
            if (m_per == tp && m_pow == tw) begin
                m_phase = 3; m_at = 1;
            end else if (t) begin
                m_per = (m_per > tp) ? imax(m_per - STEP_P, tp) : imin(m_per + STEP_P, tp);
                m_pow = m_pow + ((tw > m_pow) ? 1 : (tw < m_pow) ? -1 : 0);
            end
        end else if (m_phase == 3) begin
            if (m_per != tp || m_pow != tw) begin m_phase = 2; m_at = 0; end
        end else begin
            if (m_cnt == 0) begin m_phase = 0; m_per = START_P; end
            else m_cnt--;
        end
    endtask

    task automatic compare(input string name, input int e_st, input int e_per, input int e_pow,
                           input bit e_run, input bit e_al, input bit e_at);
        vecs++;
        if (int'(st) != e_st || int'(per_now) != e_per || int'(pow_now) != e_pow ||
            run_en != e_run || align_en != e_al || at_speed != e_at) begin
            errs++;
            $display("FAIL %s t=%0t: got state=%0d per=%0d pow=%0d run=%0b align=%0b at=%0b, expected state=%0d per=%0d pow=%0d run=%0b align=%0b at=%0b",
                     name, $time, st, per_now, pow_now, run_en, align_en, at_speed,
                     e_st, e_per, e_pow, e_run, e_al, e_at);
        end
    endtask

    task automatic cycle(input bit s, input bit t, input int sp, input int p);
        start = s; tick = t; spd = sp[24:0]; pw = p[7:0];
        @(posedge clk);
        model_clk(s, t, sp, p);
        #1;
        compare("model", m_phase, m_per, m_pow, m_run, m_align, m_at);
    endtask

    // Reset pulse strictly between clock edges: outputs must drop without a clock.
    task automatic async_reset();
        #3 nRst = 1'b0;
        #1;
        model_reset();
        compare("async_reset", 0, START_P, 0, 0, 0, 0);
        #2 nRst = 1'b1;
    endtask

    typedef struct {
        int cyc; bit s; int tick_every; int sp; int p;
        int e_st; int e_per; int e_pow; bit e_run; bit e_al; bit e_at;
    } row_t;

    row_t rows[$];

    task automatic add(input int cyc, input bit s, input int te, input int sp, input int p,
                       input int e_st, input int e_per, input int e_pow,
                       input bit e_run, input bit e_al, input bit e_at);
        row_t r;
        r.cyc = cyc; r.s = s; r.tick_every = te; r.sp = sp; r.p = p;
        r.e_st = e_st; r.e_per = e_per; r.e_pow = e_pow;
        r.e_run = e_run; r.e_al = e_al; r.e_at = e_at;
        rows.push_back(r);
    endtask

    initial begin
        bit rs;
        int rsp, rp;

        // bring-up, ramp down, retarget, clamp, stop/brake, restart to RUN
        add( 3, 0,  0, 16667, 10,  0, 20000,  0, 0, 0, 0);
        add( 1, 1,  0, 16667, 10,  1, 20000,  8, 0, 1, 0);
        add(99, 1,  0, 16667, 10,  1, 20000,  8, 0, 1, 0);
        add( 1, 1,  0, 16667, 10,  2, 20000,  8, 1, 0, 0);
        add(32, 1, 32, 16667, 10,  2, 19000,  9, 1, 0, 0);
        add(32, 1, 32, 16667, 10,  2, 18000, 10, 1, 0, 0);
        add(32, 1, 32, 16667, 10,  2, 17000, 10, 1, 0, 0);
        add( 1, 1,  1, 16667, 10,  2, 16667, 10, 1, 0, 0);
        add( 1, 1,  0, 16667, 10,  3, 16667, 10, 1, 0, 1);
        add( 1, 1,  0, 18000, 10,  2, 16667, 10, 1, 0, 0);
        add( 1, 1,  1, 18000, 10,  2, 17667, 10, 1, 0, 0);
        add( 1, 1,  1, 18000, 10,  2, 18000, 10, 1, 0, 0);
        add( 1, 1,  0, 18000, 10,  3, 18000, 10, 1, 0, 1);
        add( 1, 1,  0,     0,  0,  2, 18000, 10, 1, 0, 0);
        add(16, 1,  1,     0,  0,  2,  2000,  1, 1, 0, 0);
        add( 1, 1,  1,     0,  0,  2,  1667,  1, 1, 0, 0);
        add( 4, 1,  1,     0,  0,  3,  1667,  1, 1, 0, 1);
        add( 1, 1,  0, 18000, 10,  2,  1667,  1, 1, 0, 0);
        add( 1, 1,  1, 18000, 10,  2,  2667,  2, 1, 0, 0);
        add( 1, 0,  1, 18000, 10,  4,  2667,  0, 0, 0, 0);
        add(49, 1,  0, 18000, 10,  4,  2667,  0, 0, 0, 0);
        add( 1, 1,  0, 18000, 10,  0, 20000,  0, 0, 0, 0);
        add( 1, 1,  0, 18000, 10,  1, 20000,  8, 0, 1, 0);
        add(99, 1,  0, 18000, 10,  1, 20000,  8, 0, 1, 0);
        add( 1, 1,  0, 18000, 10,  2, 20000,  8, 1, 0, 0);
        add( 2, 1,  1, 18000, 10,  2, 18000, 10, 1, 0, 0);
        add( 1, 1,  0, 18000, 10,  3, 18000, 10, 1, 0, 1);

        nRst = 1'b0; start = 1'b0; tick = 1'b0; spd = 25'd16667; pw = 8'd10;
        model_reset();
        #12;
        compare("reset", 0, START_P, 0, 0, 0, 0);
        @(negedge clk);
        nRst = 1'b1;

        foreach (rows[k]) begin
            for (int i = 0; i < rows[k].cyc; i++)
                cycle(rows[k].s, (rows[k].tick_every != 0) && (i % rows[k].tick_every == 0),
                      rows[k].sp, rows[k].p);
            compare($sformatf("row%0d", k), rows[k].e_st, rows[k].e_per, rows[k].e_pow,
                    rows[k].e_run, rows[k].e_al, rows[k].e_at);
        end

        async_reset();

        rs = 1'b1; rsp = 16000; rp = 12;
        for (int i = 0; i < 8000; i++) begin
            if (rs) rs = ($urandom_range(0, 299) != 0);
            else    rs = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 79) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rsp = $urandom_range(0, 3000);
                    1:       rsp = $urandom_range(10000, 25000);
                    2:       rsp = $urandom_range(1600, 1700);
                    default: rsp = $urandom_range(15000, 21000);
                endcase
                rp = $urandom_range(0, 20);
            end
            cycle(rs, $urandom_range(0, 3) == 0, rsp, rp);
            if ($urandom_range(0, 1499) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
